// File: rtl/md_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package md_pkg;

    localparam int unsigned MD_XLEN = 32;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } md_op_e;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PREP = 3'd1,
        CALC = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } md_state_e;

    localparam logic [MD_XLEN-1:0] MD_DIV0_Q = {MD_XLEN{1'b1}};
    localparam logic [MD_XLEN-1:0] MD_OVF_Q  = {1'b1, {(MD_XLEN-1){1'b0}}};

    // Funct3[2] separates the divide family from the multiply family.
    function automatic logic md_is_div(input md_op_e op);
        return op[2];
    endfunction

endpackage

// File: rtl/md_step.sv
// One radix-2 iteration: shift-add for multiply, restoring subtract for divide.
module md_step
    import md_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN
) (
    input  logic            is_div,
    input  logic [XLEN-1:0] acc,
    input  logic [XLEN-1:0] q,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] acc_nxt,
    output logic [XLEN-1:0] q_nxt
);

    logic [XLEN:0] sum;
    logic [XLEN:0] shifted;
    logic [XLEN:0] diff;

    always_comb begin
        sum     = {1'b0, acc} + (q[0] ? {1'b0, b} : {(XLEN+1){1'b0}});
        shifted = {acc, q[XLEN-1]};
        diff    = shifted - {1'b0, b};
        if (is_div) begin
            // Remainder stays below the divisor, so diff's MSB is a clean borrow flag.
            if (!diff[XLEN]) begin
                acc_nxt = diff[XLEN-1:0];
                q_nxt   = {q[XLEN-2:0], 1'b1};
            end else begin
                acc_nxt = shifted[XLEN-1:0];
                q_nxt   = {q[XLEN-2:0], 1'b0};
            end
        end else begin
            acc_nxt = sum[XLEN:1];
            q_nxt   = {sum[0], q[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide unit that stalls EX while it runs.
// Optional MD_ZERO_SKIP_EN: zero-operand ops finish in one cycle.
module muldiv_sequencer
    import md_pkg::*;
#(
    parameter int unsigned XLEN = MD_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            stall_o,
    output logic            busy_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    localparam int unsigned    CW     = $clog2(XLEN);
    localparam logic [XLEN-1:0] DIV0_Q = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] OVF_Q  = {1'b1, {(XLEN-1){1'b0}}};

    md_state_e state_q, state_nxt;
    md_op_e    op_q, op_in;

    logic [XLEN-1:0]   acc_q, q_q, b_q, result_q;
    logic [XLEN-1:0]   acc_step, q_step, a_mag, b_mag;
    logic [XLEN-1:0]   special_res_c, fix_res_c, quo_fix, rem_fix;
    logic [2*XLEN-1:0] prod, prod_fix;
    logic [CW-1:0]     cnt_q;
    logic              neg_q, neg_c, a_sgn, b_sgn;
    logic              accept_c, special_c, div_in, b_zero, ovf_in;

    // Ops that bypass iteration: divide by zero, signed overflow, optional zero skip.
    always_comb begin
        op_in         = md_op_e'(funct3_i);
        div_in        = md_is_div(op_in);
        b_zero        = (op_b_i == '0);
        ovf_in        = div_in & ~funct3_i[0] & (op_a_i == OVF_Q) & (op_b_i == DIV0_Q);
        special_c     = div_in & (b_zero | ovf_in);
        special_res_c = '0;
        if (div_in & b_zero) begin
            special_res_c = funct3_i[1] ? op_a_i : DIV0_Q;
        end else if (ovf_in) begin
            special_res_c = funct3_i[1] ? '0 : OVF_Q;
        end
`ifdef MD_ZERO_SKIP_EN
        if (div_in ? ((op_a_i == '0) & ~b_zero) : ((op_a_i == '0) | b_zero)) begin
            special_c = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_nxt;
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_nxt = special_c ? DONE : PREP;
            PREP:    state_nxt = CALC;
            CALC:    if (cnt_q == CW'(XLEN-1)) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush_i) state_nxt = IDLE;
    end

    always_comb begin
        accept_c = (state_q == IDLE) & start_i & ~flush_i & reset;
        stall_o  = accept_c | (state_q == PREP) | (state_q == CALC) | (state_q == FIX);
        busy_o   = (state_q != IDLE);
        valid_o  = (state_q == DONE) & ~flush_i;
    end

    // Operand signs, magnitudes and final sign/select fix-up.
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        neg_c = 1'b0;
        case (op_q)
            OP_MULH, OP_DIV: begin
                a_sgn = q_q[XLEN-1];
                b_sgn = b_q[XLEN-1];
                neg_c = a_sgn ^ b_sgn;
            end
            OP_MULHSU: begin
                a_sgn = q_q[XLEN-1];
                neg_c = a_sgn;
            end
            OP_REM: begin
                a_sgn = q_q[XLEN-1];
                b_sgn = b_q[XLEN-1];
                neg_c = a_sgn;
            end
            default: ;
        endcase
        a_mag    = a_sgn ? -q_q : q_q;
        b_mag    = b_sgn ? -b_q : b_q;
        prod     = {acc_q, q_q};
        prod_fix = neg_q ? -prod : prod;
        quo_fix  = neg_q ? -q_q : q_q;
        rem_fix  = neg_q ? -acc_q : acc_q;
        case (op_q)
            OP_MUL:                       fix_res_c = prod_fix[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fix_res_c = prod_fix[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fix_res_c = quo_fix;
            default:                      fix_res_c = rem_fix;
        endcase
    end

    md_step #(.XLEN(XLEN)) u_step (
        .is_div  (md_is_div(op_q)),
        .acc     (acc_q),
        .q       (q_q),
        .b       (b_q),
        .acc_nxt (acc_step),
        .q_nxt   (q_step)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q     <= OP_MUL;
            acc_q    <= '0;
            q_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (accept_c) begin
                    op_q <= op_in;
                    q_q  <= op_a_i;
                    b_q  <= op_b_i;
                    if (special_c) result_q <= special_res_c;
                end
                PREP: begin
                    q_q   <= a_mag;
                    b_q   <= b_mag;
                    acc_q <= '0;
                    neg_q <= neg_c;
                    cnt_q <= '0;
                end
                CALC: begin
                    acc_q <= acc_step;
                    q_q   <= q_step;
                    cnt_q <= cnt_q + CW'(1);
                end
                FIX: if (!flush_i) result_q <= fix_res_c;
                default: ;
            endcase
        end
    end

    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized self-checking bench for muldiv_sequencer against an arithmetic model.
module tb_muldiv_sequencer;
    import md_pkg::*;

    logic        clk;
    logic        reset;
    logic        start_i;
    logic        flush_i;
    logic [2:0]  funct3_i;
    logic [31:0] op_a_i;
    logic [31:0] op_b_i;
    logic        stall_o;
    logic        busy_o;
    logic        valid_o;
    logic [31:0] result_o;

    int total = 0;
    int bad   = 0;
    logic [31:0] last_res;

    muldiv_sequencer dut (
        .clk      (clk),
        .reset    (reset),
        .start_i  (start_i),
        .flush_i  (flush_i),
        .funct3_i (funct3_i),
        .op_a_i   (op_a_i),
        .op_b_i   (op_b_i),
        .stall_o  (stall_o),
        .busy_o   (busy_o),
        .valid_o  (valid_o),
        .result_o (result_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // RV32M results from plain 64-bit arithmetic.
    function automatic logic [31:0] ref_md(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        p  = '0;
        case (f)
            3'd0: begin p = ua * ub;            return p[31:0];  end
            3'd1: begin p = sa * sb;            return p[63:32]; end
            3'd2: begin p = sa * longint'(ub);  return p[63:32]; end
            3'd3: begin p = ua * ub;            return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return MD_DIV0_Q;
                if (a == MD_OVF_Q && b == 32'hFFFF_FFFF) return MD_OVF_Q;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 32'd0) ? MD_DIV0_Q : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == MD_OVF_Q && b == 32'hFFFF_FFFF) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 32'd0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MD_ZERO_SKIP_EN
        if (!f[2] && (a == 32'd0 || b == 32'd0)) return 1;
        if (f[2] && a == 32'd0) return 1;
`endif
        return 35;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One op from accept to the following idle cycle, checking latency, stall and result.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        int          lat;
        bit          seen;
        int          k;
        exp = ref_md(f, a, b);
        lat = ref_lat(f, a, b);
        @(negedge clk);
        start_i = 1'b1; funct3_i = f; op_a_i = a; op_b_i = b;
        #1 chk("stall_accept", stall_o, 1);
        seen = 0;
        k = 0;
        while (!seen && k < lat + 3) begin
            k++;
            @(posedge clk); #1;
            if (k == 1) begin
                start_i = 1'b0; funct3_i = 3'($urandom); op_a_i = $urandom; op_b_i = $urandom;
            end
            #1;
            if (valid_o) begin
                seen = 1;
                chk("latency", k, lat);
                chk("result", result_o, exp);
                chk("stall_done", stall_o, 0);
            end else if (k < lat) begin
                chk("stall_busy", stall_o, 1);
            end
        end
        if (!seen) chk("valid_timeout", 0, 1);
        @(posedge clk); #2;
        chk("idle_busy", busy_o, 0);
        chk("idle_valid", valid_o, 0);
        chk("result_hold", result_o, exp);
        last_res = exp;
    endtask

    initial begin
        int          vcnt;
        int          vcyc [2];
        logic [31:0] vres [2];
        bit          any_valid;

        reset = 1'b0; start_i = 1'b0; flush_i = 1'b0;
        funct3_i = 3'd0; op_a_i = '0; op_b_i = '0; last_res = '0;
        #1;
        chk("rst_stall", stall_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_valid", valid_o, 0);
        chk("rst_result", result_o, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2);
        run_op(3'd5, 32'd100, 32'd7);
        run_op(3'd7, 32'd100, 32'd7);
        run_op(3'd5, 32'd5, 32'd0);
        run_op(3'd6, 32'd5, 32'd0);
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op(3'd0, 32'd0, 32'd9);
        run_op(3'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

        // Flush mid-multiply: no valid, result unchanged.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd1234; op_b_i = 32'd5678;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (k == 1) start_i = 1'b0;
        end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        #1 chk("flush_idle", busy_o, 0);
        any_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (valid_o) any_valid = 1;
        end
        chk("flush_no_valid", any_valid, 0);
        chk("flush_result", result_o, last_res);

        // Reset pulsed mid-operation clears everything immediately.
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd5; op_a_i = 32'd99999; op_b_i = 32'd13;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) start_i = 1'b0;
        end
        reset = 1'b0;
        #1;
        chk("midrst_stall", stall_o, 0);
        chk("midrst_busy", busy_o, 0);
        chk("midrst_valid", valid_o, 0);
        chk("midrst_result", result_o, 0);
        @(negedge clk);
        reset = 1'b1;
        last_res = '0;

        // Back-to-back multiplies with start held.
        vcnt = 0; vcyc[0] = 0; vcyc[1] = 0; vres[0] = '0; vres[1] = '0;
        @(negedge clk);
        start_i = 1'b1; funct3_i = 3'd0; op_a_i = 32'd3; op_b_i = 32'd4;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (valid_o) begin
                if (vcnt < 2) begin vcyc[vcnt] = k; vres[vcnt] = result_o; end
                vcnt++;
            end
            if (k == 35) begin op_a_i = 32'd5; op_b_i = 32'd6; end
            if (k == 36) chk("b2b_accept_stall", stall_o, 1);
            if (k == 37) start_i = 1'b0;
        end
        chk("b2b_count", vcnt, 2);
        chk("b2b_cyc0", vcyc[0], 35);
        chk("b2b_res0", vres[0], ref_md(3'd0, 32'd3, 32'd4));
        chk("b2b_cyc1", vcyc[1], 71);
        chk("b2b_res1", vres[1], ref_md(3'd0, 32'd5, 32'd6));

        for (int n = 0; n < 60; n++) begin
            run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
